// File: rtl/rgb_pkg.sv
// Shared definitions for the lights selector and the RGB PWM driver:
// colour word layout, PWM width and a few named colours.
package rgb_pkg;

    localparam int PWM_W    = 8;
    localparam int COLOUR_W = 24;
    localparam int N_CH     = 3;

    // Colour word is {R, G, B}, 8 bits per channel
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    localparam logic [COLOUR_W-1:0] WHITE = 24'hFFFFFF;
    localparam logic [COLOUR_W-1:0] OFF   = 24'h000000;

    // Duty of all-ones means "always on", so white has no 1/256 dropout
    localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;
    // Last count of a PWM period
    localparam logic [PWM_W-1:0] PWM_LAST  = 8'hFF;

    typedef enum int {
        CH_R = 0,
        CH_G = 1,
        CH_B = 2
    } channel_e;

    // Extract one channel's duty byte from a colour word
    function automatic logic [PWM_W-1:0] channel_duty(
        input logic [COLOUR_W-1:0] colour,
        input int                  ch
    );
        logic [PWM_W-1:0] duty;
        case (ch)
            CH_R:    duty = colour[R_MSB:R_LSB];
            CH_G:    duty = colour[G_MSB:G_LSB];
            default: duty = colour[B_MSB:B_LSB];
        endcase
        return duty;
    endfunction

    // Prescaler counter width; a single bit is kept even for PRESCALE=1
    function automatic int presc_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM output channel: compares the shared period counter against this
// channel's duty and registers the result as the LED drive.
module pwm_channel
    import rgb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [PWM_W-1:0] i_duty,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic             o_led
);

    logic w_led_next;
    logic r_led;

    // Full-scale duty forces the output on so the 255 count never drops out
    assign w_led_next = i_enable && ((i_duty == DUTY_FULL) || (i_pwm_cnt < i_duty));

    // Register the drive so the pin never sees compare glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for the RGB LED. A prescaler and an 8-bit period
// counter are shared by all channels; the colour is captured into a shadow
// register only at period boundaries (or continuously while disabled), so a
// colour change never yields a partial, glitched period.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [COLOUR_W-1:0] light,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                period_start
);

    localparam int             PW        = presc_width(PRESCALE);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0]       r_presc_cnt;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [COLOUR_W-1:0] r_shadow;

    logic                w_tick;
    logic                w_period_end;
    logic [N_CH-1:0]     w_led;

    // One count step every PRESCALE enabled cycles
    assign w_tick       = enable && (r_presc_cnt == PRESC_MAX);
    // Last clock of the last count step: the next cycle starts a new period
    assign w_period_end = w_tick && (r_pwm_cnt == PWM_LAST);

    // Prescaler: free-running while enabled, parked at zero otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_cnt <= '0;
        end else if (!enable) begin
            r_presc_cnt <= '0;
        end else if (r_presc_cnt == PRESC_MAX) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PW'(1);
        end
    end

    // Period counter: advances on each tick, wraps 255 -> 0 naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else if (!enable) begin
            r_pwm_cnt <= '0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Shadow colour: tracks the input while parked so the first period after
    // enable uses the last disabled-cycle colour; otherwise only at period end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= OFF;
        end else if (!enable || w_period_end) begin
            r_shadow <= light;
        end
    end

    // First cycle of a period is decoded from the parked/wrapped counters;
    // rst is included so the strobe stays low while reset is held
    assign period_start = enable && !rst && (r_pwm_cnt == '0) && (r_presc_cnt == '0);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [PWM_W-1:0] w_duty;

            assign w_duty = channel_duty(r_shadow, gi);

            pwm_channel u_pwm_channel (
                .clk       (clk),
                .rst       (rst),
                .i_enable  (enable),
                .i_duty    (w_duty),
                .i_pwm_cnt (r_pwm_cnt),
                .o_led     (w_led[gi])
            );
        end
    endgenerate

    assign led_r = w_led[CH_R];
    assign led_g = w_led[CH_G];
    assign led_b = w_led[CH_B];

endmodule
